// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types (parity mode, receiver states) and oversampling constant
package uart_pkg;
  typedef enum logic [1:0] {PAR_NONE, PAR_EVEN, PAR_ODD} parity_t;
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_IDLE} rx_state_t;
  localparam int OVERSAMPLE = 16;
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: oversampling tick every CLK_FREQ/(BAUD*16) clocks; clear holds the phase at 0 (ports: clk, reset, clear, tick)
module uart_baud_tick import uart_pkg::*; #(
  parameter int CLK_FREQ = 12_000_000,
  parameter int BAUD = 9600
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);
  localparam int CLKS_PER_TICK = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int W = CLKS_PER_TICK > 1 ? $clog2(CLKS_PER_TICK) : 1;
  logic [W-1:0] cnt;
  always_ff @(posedge clk) begin
    if (reset || clear) cnt <= '0;
    else cnt <= tick ? '0 : cnt + W'(1);
  end
  assign tick = cnt == W'(CLKS_PER_TICK - 1);
endmodule

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: configurable UART receiver (ports: clk, reset, rx_in, data_ack in; data_out, data_valid, framing_error, parity_error, overrun_error, break_detect out)
module uart_rx_cfg import uart_pkg::*; #(
  parameter int CLK_FREQ = 12_000_000,
  parameter int BAUD = 9600,
  parameter int DATA_BITS = 8,
  parameter parity_t PARITY = PAR_NONE,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_in,
  input  logic                 data_ack,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 framing_error,
  output logic                 parity_error,
  output logic                 overrun_error,
  output logic                 break_detect
);
  rx_state_t state, state_nx;
  logic sync1, rx_sync, tick;
  logic [3:0] tick_idx, bit_cnt;
  logic [1:0] votes;
  logic [DATA_BITS-1:0] shreg;
  logic par_err, stop_err, any_one;
  logic smp, mid, last_tick, last_bit, done, fe, good, load;
  uart_baud_tick #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) u_tick (
    .clk(clk),
    .reset(reset),
    .clear(state == S_IDLE),
    .tick(tick)
  );
  assign smp = (votes[0] & votes[1]) | (votes[0] & rx_sync) | (votes[1] & rx_sync);
  assign mid = tick && tick_idx == 4'd9;
  assign last_tick = tick && tick_idx == 4'd15;
  assign last_bit = bit_cnt == 4'(state == S_STOP ? STOP_BITS - 1 : DATA_BITS - 1);
  assign done = state == S_STOP && mid && last_bit;
  assign fe = stop_err | ~smp;
  assign good = !fe && !par_err;
  assign load = done && good && (!data_valid || data_ack);
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:      state_nx = rx_sync ? S_IDLE : S_START;
      S_START:     state_nx = (mid && smp) ? S_IDLE : last_tick ? S_DATA : S_START;
      S_DATA:      state_nx = (last_tick && last_bit) ? (PARITY == PAR_NONE ? S_STOP : S_PARITY) : S_DATA;
      S_PARITY:    state_nx = last_tick ? S_STOP : S_PARITY;
      S_STOP:      state_nx = done ? (fe ? S_WAIT_IDLE : S_IDLE) : S_STOP;
      S_WAIT_IDLE: state_nx = rx_sync ? S_IDLE : S_WAIT_IDLE;
      default:     state_nx = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      {sync1, rx_sync} <= 2'b11;
      state <= S_IDLE;
      tick_idx <= '0;
      bit_cnt <= '0;
      votes <= '0;
      shreg <= '0;
      par_err <= 1'b0;
      stop_err <= 1'b0;
      any_one <= 1'b0;
      data_out <= '0;
      data_valid <= 1'b0;
      framing_error <= 1'b0;
      parity_error <= 1'b0;
      overrun_error <= 1'b0;
      break_detect <= 1'b0;
    end else begin
      {sync1, rx_sync} <= {rx_in, sync1};
      state <= state_nx;
      framing_error <= done && fe;
      parity_error <= done && par_err;
      overrun_error <= done && good && data_valid && !data_ack;
      break_detect <= done && !(any_one | smp);
      data_valid <= load || (data_valid && !data_ack);
      if (load) data_out <= shreg;
      if (state == S_IDLE) begin
        tick_idx <= '0;
        bit_cnt <= '0;
        par_err <= 1'b0;
        stop_err <= 1'b0;
        any_one <= 1'b0;
      end else if (tick) begin
        tick_idx <= tick_idx + 4'd1;
        if (tick_idx == 4'd7) votes[0] <= rx_sync;
        if (tick_idx == 4'd8) votes[1] <= rx_sync;
        if (mid) any_one <= any_one | smp;
        if (mid && state == S_DATA) shreg <= {smp, shreg[DATA_BITS-1:1]};
        if (mid && state == S_PARITY) par_err <= smp ^ (PARITY == PAR_ODD) ^ (^shreg);
        if (mid && state == S_STOP && !smp) stop_err <= 1'b1;
        if (last_tick) bit_cnt <= state_nx == state ? bit_cnt + 4'd1 : 4'd0;
      end
    end
  end
endmodule

// File: doc/uart_rx_cfg.md
UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 Parameter CLK_FREQ, 12_000_000, input clock frequency in Hz.
REQ-002 Parameter BAUD, 9600, line bit rate in bit/s.
REQ-003 Parameter DATA_BITS, 8, data bits per frame; legal range 5..9, sent LSB first.
REQ-004 Parameter PARITY, PAR_NONE, one of PAR_NONE / PAR_EVEN / PAR_ODD.
REQ-005 Parameter STOP_BITS, 1, stop bits per frame; legal values 1 or 2.
REQ-006 Port clk, input, 1, single clock; all logic on its rising edge.
REQ-007 Port reset, input, 1, synchronous, active-high reset.
REQ-008 Port rx_in, input, 1, asynchronous serial line; idles high.
REQ-009 Port data_out, output, DATA_BITS, holding register with the last accepted frame.
REQ-010 Port data_valid, output, 1, data_out holds an unconsumed frame.
REQ-011 Port data_ack, input, 1, consumer accepts data_out when data_valid=1.
REQ-012 Port framing_error, output, 1, one-clock pulse: a stop bit was sampled 0.
REQ-013 Port parity_error, output, 1, one-clock pulse: parity mismatch.
REQ-014 Port overrun_error, output, 1, one-clock pulse: a good frame was dropped because the holding register was full.
REQ-015 Port break_detect, output, 1, one-clock pulse: data, parity and stop bits were all 0.

Function
REQ-016 SHALL pass rx_in through a 2-FF synchronizer; rx_sync is the second FF output.
REQ-017 SHALL generate a tick every CLKS_PER_TICK = CLK_FREQ/(BAUD*16) clocks.
REQ-018 The tick counter SHALL be held at 0 while in IDLE, so tick phase aligns to the start edge.
REQ-019 SHALL count 16 ticks per bit (index 0..15).
REQ-020 Each bit value SHALL be the majority of rx_sync at ticks 7, 8 and 9.
REQ-021 States SHALL be IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
REQ-022 IDLE -> START when rx_sync=0.
REQ-023 START: a majority value of 1 is a false start -> IDLE with no outputs asserted; a value of 0 -> DATA after tick 15.
REQ-024 DATA: SHALL shift in DATA_BITS bits, bit 0 first. After tick 15 of the last bit -> PARITY if PARITY!=PAR_NONE, otherwise -> STOP.
REQ-025 PARITY: compare the sampled bit with the XOR of the data bits; even parity expects XOR, odd parity expects ~XOR. -> STOP after tick 15.
REQ-026 STOP: sample each of STOP_BITS stop bits. The frame completes at tick 9 of the last stop bit, not tick 15, to tolerate baud mismatch.
REQ-027 Frame completion, all stop bits 1 -> IDLE.
REQ-028 Frame completion, any stop bit 0 -> WAIT_IDLE.
REQ-029 WAIT_IDLE -> IDLE only once rx_sync=1, so a held-low line cannot retrigger START.
REQ-030 Good frame = no framing error and no parity error.
REQ-031 On a good frame with data_valid=0, or with data_valid=1 and data_ack=1 in the same cycle: load data_out and set data_valid=1 on the next clock.
REQ-032 On a good frame with data_valid=1 and data_ack=0: pulse overrun_error; keep the old data_out and discard the new frame.
REQ-033 Bad frames SHALL NOT load data_out; they pulse framing_error and/or parity_error on the clock after completion.
REQ-034 break_detect SHALL pulse together with framing_error when all sampled bits of the frame were 0.
REQ-035 data_valid SHALL clear on the clock after data_ack=1 unless a simultaneous reload occurs (REQ-031).
REQ-036 data_ack while data_valid=0 SHALL be ignored.

Reset
REQ-037 reset SHALL force state=IDLE and clear the tick, bit and data counters.
REQ-038 reset SHALL set data_out=0, data_valid=0 and all error and break pulses to 0.
REQ-039 reset SHALL set both synchronizer FFs to 1 (idle line level).
REQ-040 reset mid-frame SHALL abort the frame with no output pulses; reception resumes at the next falling edge after reset deasserts.

Structure
REQ-041 Package uart_pkg SHALL hold parity_t (PAR_NONE/PAR_EVEN/PAR_ODD), the rx state enum, and the constant OVERSAMPLE=16.
REQ-042 The tick generator SHALL be sub-module uart_baud_tick (parameters CLK_FREQ, BAUD; ports clk, reset, clear, tick).
REQ-043 All other logic SHALL reside in uart_rx_cfg.

Verification
Defaults: CLKS_PER_TICK=78, 1248 clocks per bit.
REQ-044 8N1, frame 0xA5 at the nominal rate: data_out=0xA5, data_valid=1; no error pulses.
REQ-045 PARITY=PAR_EVEN, 0x03 sent with parity bit 1: parity_error pulses once; data_valid stays 0.
REQ-046 rx_in low for 600 clocks, then high: false start; no outputs asserted; a following frame 0x3C is received correctly.
REQ-047 Two frames 0x11 then 0x22 with data_ack held 0: data_out=0x11 and overrun_error pulses once; acking after the second frame's overrun pulse clears data_valid.
REQ-048 rx_in held low for 20 bit times: framing_error and break_detect pulse once each; no START re-entry until rx_in returns high.
REQ-049 STOP_BITS=2, second stop bit driven 0: framing_error pulses.
REQ-050 Baud offset +3%, 8N1 frame 0x5A: still received correctly.
REQ-051 reset asserted during data bit 4: no pulses; the next frame 0x77 is received correctly.
